// File: rtl/multi_color_tracker.sv
// Multi-channel colour centroid tracker: per-channel SAD match, coordinate sums and a shared
// restoring divider. Define TRACK_BBOX_EN to add per-channel bounding-box outputs.
module multi_color_tracker #(
    parameter int unsigned FRAME_W = 640,
    parameter int unsigned FRAME_H = 480,
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned PIX_W   = 24,
    parameter int unsigned THR_W   = 16,
    parameter int unsigned SUM_W   = 40,
    parameter int unsigned CNT_W   = 20,
    parameter int unsigned COORD_W = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        s,
    input  logic [PIX_W-1:0]            data_in,
    input  logic                        valid,
    input  logic [NUM_CH*PIX_W-1:0]     ref_color,
    input  logic [NUM_CH*THR_W-1:0]     threshold,
    output logic                        busy,
    output logic                        done,
    output logic [NUM_CH-1:0]           found,
    output logic [NUM_CH*COORD_W-1:0]   x_pos,
    output logic [NUM_CH*COORD_W-1:0]   y_pos
`ifdef TRACK_BBOX_EN
    ,
    output logic [NUM_CH*COORD_W-1:0]   bbox_xmin,
    output logic [NUM_CH*COORD_W-1:0]   bbox_xmax,
    output logic [NUM_CH*COORD_W-1:0]   bbox_ymin,
    output logic [NUM_CH*COORD_W-1:0]   bbox_ymax
`endif
);
    localparam int unsigned CW   = PIX_W / 3;
    localparam int unsigned SADW = CW + 2;
    localparam int unsigned CMPW = (SADW > THR_W) ? SADW : THR_W;
    localparam int unsigned NDIV = 2 * NUM_CH;
    localparam int unsigned IW   = $clog2(NDIV);
    localparam int unsigned SW   = $clog2(SUM_W + 1);

    typedef enum logic [1:0] {StIdle, StScan, StDiv, StDone} state_e;

    state_e                    state_q, state_d;
    logic [COORD_W-1:0]        x_q, x_d, y_q, y_d;
    logic [NUM_CH*PIX_W-1:0]   ref_q, ref_d;
    logic [NUM_CH*THR_W-1:0]   thr_q, thr_d;
    logic [CNT_W-1:0]          cnt_q [NUM_CH];
    logic [CNT_W-1:0]          cnt_d [NUM_CH];
    logic [SUM_W-1:0]          xsum_q [NUM_CH];
    logic [SUM_W-1:0]          xsum_d [NUM_CH];
    logic [SUM_W-1:0]          ysum_q [NUM_CH];
    logic [SUM_W-1:0]          ysum_d [NUM_CH];
    logic [SUM_W-1:0]          dvd_q, dvd_d;
    logic [CNT_W-1:0]          rem_q, rem_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [SW-1:0]             step_q, step_d;
    logic [COORD_W-1:0]        res_q [NDIV];
    logic [COORD_W-1:0]        res_d [NDIV];
    logic                      busy_q, busy_d, done_q, done_d;
    logic [NUM_CH-1:0]         found_q, found_d;
    logic [NUM_CH*COORD_W-1:0] xpos_q, xpos_d, ypos_q, ypos_d;
`ifdef TRACK_BBOX_EN
    logic [COORD_W-1:0]        xmin_q [NUM_CH];
    logic [COORD_W-1:0]        xmin_d [NUM_CH];
    logic [COORD_W-1:0]        xmax_q [NUM_CH];
    logic [COORD_W-1:0]        xmax_d [NUM_CH];
    logic [COORD_W-1:0]        ymin_q [NUM_CH];
    logic [COORD_W-1:0]        ymin_d [NUM_CH];
    logic [COORD_W-1:0]        ymax_q [NUM_CH];
    logic [COORD_W-1:0]        ymax_d [NUM_CH];
    logic [NUM_CH*COORD_W-1:0] bxmin_q, bxmin_d, bxmax_q, bxmax_d;
    logic [NUM_CH*COORD_W-1:0] bymin_q, bymin_d, bymax_q, bymax_d;
`endif

    logic [NUM_CH-1:0] match;
    logic [CW-1:0]     pc, rc;
    logic [SADW-1:0]   sad;

    always_comb begin
        match = '0;
        pc    = '0;
        rc    = '0;
        sad   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sad = '0;
            for (int c = 0; c < 3; c++) begin
                pc  = data_in[c*CW +: CW];
                rc  = ref_q[k*PIX_W + c*CW +: CW];
                sad = sad + ((pc >= rc) ? SADW'(pc - rc) : SADW'(rc - pc));
            end
            match[k] = CMPW'(sad) <= CMPW'(thr_q[k*THR_W +: THR_W]);
        end
    end

    logic [CNT_W-1:0] divisor;
    logic [SUM_W-1:0] dividend;
    logic [CNT_W:0]   rem_sh, trial;

    // Division order is ch0 x, ch0 y, ch1 x, ... selected by idx_q.
    always_comb begin
        divisor  = '0;
        dividend = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx_q == IW'(2 * k)) begin
                divisor  = cnt_q[k];
                dividend = xsum_q[k];
            end
            if (idx_q == IW'(2 * k + 1)) begin
                divisor  = cnt_q[k];
                dividend = ysum_q[k];
            end
        end
        rem_sh = {rem_q, dvd_q[SUM_W-1]};
        trial  = rem_sh - {1'b0, divisor};
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        ref_d   = ref_q;
        thr_d   = thr_q;
        cnt_d   = cnt_q;
        xsum_d  = xsum_q;
        ysum_d  = ysum_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        step_d  = step_q;
        res_d   = res_q;
        done_d  = 1'b0;
        found_d = found_q;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
`ifdef TRACK_BBOX_EN
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        bxmin_d = bxmin_q;
        bxmax_d = bxmax_q;
        bymin_d = bymin_q;
        bymax_d = bymax_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (s) begin
                    state_d = StScan;
                    ref_d   = ref_color;
                    thr_d   = threshold;
                    x_d     = '0;
                    y_d     = '0;
                    for (int k = 0; k < NUM_CH; k++) begin
                        cnt_d[k]  = '0;
                        xsum_d[k] = '0;
                        ysum_d[k] = '0;
`ifdef TRACK_BBOX_EN
                        xmin_d[k] = '1;
                        xmax_d[k] = '0;
                        ymin_d[k] = '1;
                        ymax_d[k] = '0;
`endif
                    end
                end
            end
            StScan: begin
                if (valid) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (match[k]) begin
                            cnt_d[k]  = cnt_q[k] + 1'b1;
                            xsum_d[k] = xsum_q[k] + SUM_W'(x_q);
                            ysum_d[k] = ysum_q[k] + SUM_W'(y_q);
`ifdef TRACK_BBOX_EN
                            if (x_q < xmin_q[k]) xmin_d[k] = x_q;
                            if (x_q > xmax_q[k]) xmax_d[k] = x_q;
                            if (y_q < ymin_q[k]) ymin_d[k] = y_q;
                            if (y_q > ymax_q[k]) ymax_d[k] = y_q;
`endif
                        end
                    end
                    if (x_q == COORD_W'(FRAME_W - 1)) begin
                        x_d = '0;
                        if (y_q == COORD_W'(FRAME_H - 1)) begin
                            state_d = StDiv;
                            idx_d   = '0;
                            step_d  = '0;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            StDiv: begin
                if (step_q == '0) begin
                    dvd_d  = dividend;
                    rem_d  = '0;
                    step_d = SW'(1);
                end else begin
                    if (!trial[CNT_W]) begin
                        rem_d = trial[CNT_W-1:0];
                        dvd_d = {dvd_q[SUM_W-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[CNT_W-1:0];
                        dvd_d = {dvd_q[SUM_W-2:0], 1'b0};
                    end
                    if (step_q == SW'(SUM_W)) begin
                        for (int i = 0; i < NDIV; i++) begin
                            if (idx_q == IW'(i)) res_d[i] = dvd_d[COORD_W-1:0];
                        end
                        step_d = '0;
                        if (idx_q == IW'(NDIV - 1)) state_d = StDone;
                        else                        idx_d   = idx_q + 1'b1;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            StDone: begin
                // Empty channels keep their previous results.
                for (int k = 0; k < NUM_CH; k++) begin
                    found_d[k] = |cnt_q[k];
                    if (|cnt_q[k]) begin
                        xpos_d[k*COORD_W +: COORD_W] = res_q[2*k];
                        ypos_d[k*COORD_W +: COORD_W] = res_q[2*k+1];
`ifdef TRACK_BBOX_EN
                        bxmin_d[k*COORD_W +: COORD_W] = xmin_q[k];
                        bxmax_d[k*COORD_W +: COORD_W] = xmax_q[k];
                        bymin_d[k*COORD_W +: COORD_W] = ymin_q[k];
                        bymax_d[k*COORD_W +: COORD_W] = ymax_q[k];
`endif
                    end
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StScan) || (state_d == StDiv);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            ref_q   <= '0;
            thr_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            found_q <= '0;
            xpos_q  <= '0;
            ypos_q  <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_q[k]  <= '0;
                xsum_q[k] <= '0;
                ysum_q[k] <= '0;
`ifdef TRACK_BBOX_EN
                xmin_q[k] <= '0;
                xmax_q[k] <= '0;
                ymin_q[k] <= '0;
                ymax_q[k] <= '0;
`endif
            end
            for (int i = 0; i < NDIV; i++) res_q[i] <= '0;
`ifdef TRACK_BBOX_EN
            bxmin_q <= '0;
            bxmax_q <= '0;
            bymin_q <= '0;
            bymax_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ref_q   <= ref_d;
            thr_q   <= thr_d;
            cnt_q   <= cnt_d;
            xsum_q  <= xsum_d;
            ysum_q  <= ysum_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            found_q <= found_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
`ifdef TRACK_BBOX_EN
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            bxmin_q <= bxmin_d;
            bxmax_q <= bxmax_d;
            bymin_q <= bymin_d;
            bymax_q <= bymax_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign found = found_q;
    assign x_pos = xpos_q;
    assign y_pos = ypos_q;
`ifdef TRACK_BBOX_EN
    assign bbox_xmin = bxmin_q;
    assign bbox_xmax = bxmax_q;
    assign bbox_ymin = bymin_q;
    assign bbox_ymax = bymax_q;
`endif

endmodule

// File: tb/tb_multi_color_tracker.sv
// Scoreboard bench for multi_color_tracker on an 8x4 frame with two channels; frames are
// modelled pixel-by-pixel and the monitor checks every done pulse against the queue.
module tb_multi_color_tracker;
    localparam int FW   = 8;
    localparam int FH   = 4;
    localparam int NCH  = 2;
    localparam int PW   = 24;
    localparam int TW   = 16;
    localparam int CWD  = 16;
    localparam int NPIX = FW * FH;
    localparam int LAT  = 2 * NCH * (40 + 1) + 1;

    logic                clk = 1'b0;
    logic                resetn = 1'b1;
    logic                s = 1'b0;
    logic                valid = 1'b0;
    logic [PW-1:0]       data_in = '0;
    logic [NCH*PW-1:0]   ref_color = '0;
    logic [NCH*TW-1:0]   threshold = '0;
    logic                busy, done;
    logic [NCH-1:0]      found;
    logic [NCH*CWD-1:0]  x_pos, y_pos;
`ifdef TRACK_BBOX_EN
    logic [NCH*CWD-1:0]  bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
`endif

    multi_color_tracker #(
        .FRAME_W(FW), .FRAME_H(FH), .NUM_CH(NCH), .PIX_W(PW), .THR_W(TW),
        .SUM_W(40), .CNT_W(20), .COORD_W(CWD)
    ) dut (
        .clk(clk), .resetn(resetn), .s(s), .data_in(data_in), .valid(valid),
        .ref_color(ref_color), .threshold(threshold), .busy(busy), .done(done),
        .found(found), .x_pos(x_pos), .y_pos(y_pos)
`ifdef TRACK_BBOX_EN
        , .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax),
        .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NCH-1:0]     found;
        logic [NCH*CWD-1:0] xp, yp, bx0, bx1, by0, by1;
        int                 acc;
    } exp_t;

    exp_t          exp_q[$];
    int            total = 0;
    int            bad = 0;
    logic [PW-1:0] pix [NPIX];
    int            prev_x [NCH], prev_y [NCH];
    int            prev_bx0 [NCH], prev_bx1 [NCH], prev_by0 [NCH], prev_by1 [NCH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < NCH; k++) begin
            prev_x[k] = 0; prev_y[k] = 0;
            prev_bx0[k] = 0; prev_bx1[k] = 0; prev_by0[k] = 0; prev_by1[k] = 0;
        end
    endtask

    // Reference: whole-frame arithmetic over the pixel array with the start-time settings.
    task automatic model_frame(input logic [NCH*PW-1:0] rcol, input logic [NCH*TW-1:0] th,
                               output exp_t e);
        int cnt, sx, sy, sad, p, r, xmn, xmx, ymn, ymx, px, py;
        e.found = '0;
        for (int k = 0; k < NCH; k++) begin
            cnt = 0; sx = 0; sy = 0; xmn = FW; xmx = -1; ymn = FH; ymx = -1;
            for (int i = 0; i < NPIX; i++) begin
                sad = 0;
                for (int c = 0; c < 3; c++) begin
                    p = int'(pix[i][c*8 +: 8]);
                    r = int'(rcol[k*PW + c*8 +: 8]);
                    sad += (p > r) ? p - r : r - p;
                end
                if (sad <= int'(th[k*TW +: TW])) begin
                    px = i % FW; py = i / FW;
                    cnt++; sx += px; sy += py;
                    if (px < xmn) xmn = px;
                    if (px > xmx) xmx = px;
                    if (py < ymn) ymn = py;
                    if (py > ymx) ymx = py;
                end
            end
            e.found[k] = (cnt > 0);
            if (cnt > 0) begin
                prev_x[k] = sx / cnt; prev_y[k] = sy / cnt;
                prev_bx0[k] = xmn; prev_bx1[k] = xmx; prev_by0[k] = ymn; prev_by1[k] = ymx;
            end
            e.xp[k*CWD +: CWD]  = CWD'(prev_x[k]);
            e.yp[k*CWD +: CWD]  = CWD'(prev_y[k]);
            e.bx0[k*CWD +: CWD] = CWD'(prev_bx0[k]);
            e.bx1[k*CWD +: CWD] = CWD'(prev_bx1[k]);
            e.by0[k*CWD +: CWD] = CWD'(prev_by0[k]);
            e.by1[k*CWD +: CWD] = CWD'(prev_by1[k]);
        end
    endtask

    task automatic run_frame(input logic [NCH*PW-1:0] rcol, input logic [NCH*TW-1:0] th,
                             input bit gaps, input int nsend, input bit push);
        exp_t e;
        int   i;
        @(posedge clk); #1;
        ref_color = rcol; threshold = th; s = 1'b1;
        @(posedge clk); #1;
        s = 1'b0;
        check("busy_after_start", busy, 1);
        if (gaps) begin
            ref_color = {24'($urandom), 24'($urandom)};
            threshold = {16'($urandom), 16'($urandom)};
        end
        i = 0;
        while (i < nsend) begin
            if (gaps && $urandom_range(1, 0) == 0) begin
                valid = 1'b0; data_in = 24'($urandom); s = 1'($urandom);
            end else begin
                valid = 1'b1; data_in = pix[i]; i++;
                s = gaps ? 1'($urandom) : 1'b0;
            end
            @(posedge clk); #1;
        end
        valid = 1'b0; s = 1'b0; data_in = 24'($urandom);
        if (push && nsend == NPIX) begin
            model_frame(rcol, th, e);
            e.acc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", n);
            exp_q.delete();
        end
    endtask

    task automatic do_reset(input string tag);
        resetn = 1'b0;
        #1;
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_found"}, found, 0);
        check({tag, "_xpos"}, x_pos, 0);
        check({tag, "_ypos"}, y_pos, 0);
        exp_q.delete();
        clear_model();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic fill_bg(input logic [PW-1:0] v);
        for (int i = 0; i < NPIX; i++) pix[i] = v;
    endtask

    task automatic scen_a(input bit gaps);
        fill_bg('0);
        pix[10] = 24'hFF0000; pix[12] = 24'hFF0000;
        pix[26] = 24'hFF0000; pix[28] = 24'hFF0000;
        run_frame({24'h0000FF, 24'hFF0000}, {16'd0, 16'd10}, gaps, NPIX, 1'b1);
        wait_done();
    endtask

    task automatic rand_frame(input bit gaps);
        logic [NCH*PW-1:0] rcol;
        logic [NCH*TW-1:0] th;
        rcol = {24'($urandom), 24'($urandom)};
        th   = {16'($urandom_range(40, 0)), 16'($urandom_range(40, 0))};
        for (int i = 0; i < NPIX; i++) begin
            case ($urandom_range(2, 0))
                0:       pix[i] = rcol[23:0] ^ (24'($urandom) & 24'h070707);
                1:       pix[i] = rcol[47:24] ^ (24'($urandom) & 24'h070707);
                default: pix[i] = 24'($urandom);
            endcase
        end
        run_frame(rcol, th, gaps, NPIX, 1'b1);
        wait_done();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done=1, expected no pending frame");
                end else begin
                    e = exp_q.pop_front();
                    check("found", found, e.found);
                    check("x_pos", x_pos, e.xp);
                    check("y_pos", y_pos, e.yp);
                    check("latency", 64'(cyc - e.acc), LAT);
                    check("busy_at_done", busy, 0);
`ifdef TRACK_BBOX_EN
                    check("bbox_xmin", bbox_xmin, e.bx0);
                    check("bbox_xmax", bbox_xmax, e.bx1);
                    check("bbox_ymin", bbox_ymin, e.by0);
                    check("bbox_ymax", bbox_ymax, e.by1);
`endif
                end
            end
        end
    end

    initial begin
        clear_model();
        #1 resetn = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_found", found, 0);
        check("rst_xpos", x_pos, 0);
        check("rst_ypos", y_pos, 0);
        @(negedge clk);
        resetn = 1'b1;

        scen_a(1'b0);
        check("a_found0", found[0], 1);
        check("a_found1", found[1], 0);
        check("a_x0", x_pos[15:0], 3);
        check("a_y0", y_pos[15:0], 2);
`ifdef TRACK_BBOX_EN
        check("a_bxmin", bbox_xmin[15:0], 2);
        check("a_bxmax", bbox_xmax[15:0], 4);
        check("a_bymin", bbox_ymin[15:0], 1);
        check("a_bymax", bbox_ymax[15:0], 3);
`endif

        fill_bg('0);
        pix[21] = 24'h858080;
        run_frame({24'h123456, 24'h808080}, {16'd0, 16'd5}, 1'b0, NPIX, 1'b1);
        wait_done();
        check("thr5_x0", x_pos[15:0], 5);
        run_frame({24'h123456, 24'h808080}, {16'd0, 16'd4}, 1'b0, NPIX, 1'b1);
        wait_done();
        check("thr4_found0", found[0], 0);
        check("thr4_x0_held", x_pos[15:0], 5);

        fill_bg(24'hFFFFFF);
        pix[3] = 24'h102434; pix[17] = 24'h102030; pix[30] = 24'h102838;
        run_frame({24'h102838, 24'h102030}, {16'd20, 16'd20}, 1'b0, NPIX, 1'b1);
        wait_done();

        scen_a(1'b1);
        for (int n = 0; n < 6; n++) rand_frame(1'b1);
        for (int n = 0; n < 2; n++) rand_frame(1'b0);

        rand_frame(1'b0);
        run_frame({24'h0000FF, 24'hFF0000}, {16'd10, 16'd10}, 1'b0, 13, 1'b0);
        do_reset("rst_scan");
        scen_a(1'b0);

        rand_frame(1'b0);
        run_frame({24'h0000FF, 24'hFF0000}, {16'd10, 16'd10}, 1'b0, NPIX, 1'b0);
        repeat (60) @(posedge clk);
        #1;
        do_reset("rst_div");
        rand_frame(1'b1);
        scen_a(1'b0);

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_color_tracker.md
Name: multi_color_tracker

Overview:
Parametrised successor to the single-colour centroid tracker. Scans one raster frame of streamed pixels and compares each pixel against NUM_CH reference colours, each with its own threshold. Accumulates per-channel match count and x/y coordinate sums, then computes each centroid with a shared sequential divider. Sits between the pixel source (camera/VDMA stream) and the stamp/drag control logic, driven by a start pulse.

Parameters:
FRAME_W, 640, pixels per line
FRAME_H, 480, lines per frame
NUM_CH, 2, number of independent colour channels
PIX_W, 24, pixel width; three equal components of PIX_W/3 bits (R high, B low); must be divisible by 3
THR_W, 16, per-channel threshold width
SUM_W, 40, per-channel coordinate-sum width
CNT_W, 20, per-channel match-count width
COORD_W, 16, output coordinate width

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
s  in  1  start; sampled only in IDLE
data_in  in  PIX_W  pixel, raster order
valid  in  1  data_in qualifier; consumed only in SCAN
ref_color  in  NUM_CH*PIX_W  channel k at [k*PIX_W +: PIX_W]
threshold  in  NUM_CH*THR_W  channel k at [k*THR_W +: THR_W]
busy  out  1  high in SCAN and DIV
done  out  1  one-cycle pulse; results valid
found  out  NUM_CH  bit k = channel k matched >=1 pixel in last frame
x_pos  out  NUM_CH*COORD_W  channel k centroid x
y_pos  out  NUM_CH*COORD_W  channel k centroid y

Behaviour:
- Reset (async, resetn=0): state IDLE; all counters, sums, divider regs cleared; busy=0, done=0, found=0, x_pos=0, y_pos=0. Reset mid-frame or mid-divide aborts with no partial update.
- States: IDLE -> SCAN on s=1 -> DIV on edge accepting last pixel -> DONE -> IDLE.
- IDLE->SCAN: latch ref_color and threshold into internal registers (later input changes have no effect this frame); clear x, y, sums, counts.
- SCAN: each cycle with valid=1 is one pixel at (x,y). Per channel, SAD = sum over components of |p-r|, computed at full width with no wrap. Match iff SAD <= threshold (inclusive). On match: count+=1, xsum+=x, ysum+=y. x increments; at x=FRAME_W-1, x wraps to 0 and y increments. valid=0 stalls with no state change.
- Last pixel is (FRAME_W-1, FRAME_H-1). Its match is included, then the FSM enters DIV.
- DIV: one shared restoring divider, 1 quotient bit per cycle, SUM_W iteration cycles plus 1 load cycle per division. Order: ch0 x, ch0 y, ch1 x, ... (2*NUM_CH divisions). All divisions always run, giving fixed latency.
- Quotient is truncated and takes its low COORD_W bits.
- Division with count=0: result discarded; that channel's x_pos/y_pos hold their previous values and found[k]=0.
- Outputs update together in DONE, never during DIV. DONE asserts done for exactly 1 cycle, then returns to IDLE.
- Latency: done is high 2*NUM_CH*(SUM_W+1)+1 cycles after the edge accepting the last pixel (165 at defaults).
- Ignored inputs: s ignored outside IDLE; valid ignored outside SCAN. s=1 in DONE is not queued. s held high re-arms on the IDLE cycle after DONE.

Optional Feature:
Macro TRACK_BBOX_EN.
- Defined: adds outputs bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax, each NUM_CH*COORD_W. Per channel, min/max of matched coordinates, tracked during SCAN and updated in DONE alongside x_pos. Channels with count=0 hold previous values. Reset value 0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- FRAME_W=8, FRAME_H=4, NUM_CH=2: ch0 matches only pixels (2,1),(4,1),(2,3),(4,3) -> found=2'b?1 with found[0]=1, x_pos ch0=3, y_pos ch0=2, done exactly 165 cycles after last pixel.
- Threshold boundary: ref=0x808080, pixel 0x858080 (SAD=5), threshold 5 -> match; threshold 4 -> no match, found[0]=0, x_pos/y_pos unchanged from prior frame.
- valid toggled randomly (50%), with ref_color/threshold changed mid-SCAN -> results identical to the gap-free run with the start-time values.
- Channel overlap: one pixel satisfies both channels -> both counts include it. Channel with no matches -> found bit 0, other channel correct.
- resetn pulsed low mid-SCAN and again mid-DIV -> all outputs 0 immediately (async). Fresh s then yields a correct frame.
- TRACK_BBOX_EN defined: first scenario -> bbox_xmin=2, bbox_xmax=4, bbox_ymin=1, bbox_ymax=3 for ch0.
